// File: rtl/scv_video_pkg.sv
// Shared types and constants for the epochtv1 single-frame video capture sink.
package scv_video_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWaitVs,
      StWaitVsLow,
      StCapture,
      StDone
   } cap_state_e;

   localparam int unsigned ErrWidthIdx = 0;
   localparam int unsigned ErrXOvfIdx  = 1;
   localparam int unsigned ErrYOvfIdx  = 2;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

endpackage

// File: rtl/scv_video_capture_if.sv
// Pixel stream in, framebuffer write port out. The master drives the stream, the slave captures.
interface scv_video_capture_if #(
   parameter int unsigned XW = 8,
   parameter int unsigned YW = 8
) ();
   import scv_video_pkg::*;

   logic             ce;
   logic             de;
   logic             hs;
   logic             vs;
   rgb_t             rgb;
   logic [XW+YW-1:0] fb_a;
   rgb_t             fb_d;
   logic             fb_we;

   modport master (
      output ce, de, hs, vs, rgb,
      input  fb_a, fb_d, fb_we
   );

   modport slave (
      input  ce, de, hs, vs, rgb,
      output fb_a, fb_d, fb_we
   );

endinterface

// File: rtl/scv_sync_edge.sv
// Edge detector for one stream signal; history advances only on pixel clock-enable cycles.
module scv_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic ce_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
      end else if (ce_i) begin
         prev_q <= d_i;
      end
   end

   assign rise_o = ce_i & d_i & ~prev_q;
   assign fall_o = ce_i & ~d_i & prev_q;

endmodule

// File: rtl/scv_video_capture.sv
// Captures one full video frame into an external {y,x}-addressed framebuffer and
// reports the measured active geometry plus sticky stream errors.
module scv_video_capture
   import scv_video_pkg::*;
#(
   parameter int unsigned XW = 8,
   parameter int unsigned YW = 8
) (
   input  logic                clk,
   input  logic                rst,
   scv_video_capture_if.slave  vid,
   input  logic                arm_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [XW:0]         width_o,
   output logic [YW:0]         height_o,
   output logic [9:0]          hlines_o,
   output logic [2:0]          err_o
);

   localparam logic [XW:0] XMax   = {1'b1, {XW{1'b0}}};
   localparam logic [YW:0] YMax   = {1'b1, {YW{1'b0}}};
   localparam logic [9:0]  HlMax  = 10'h3ff;

   cap_state_e  state_q;
   logic [XW:0] x_q;
   logic [YW:0] y_q;
   logic        de_rise, de_fall, hs_rise, hs_fall, vs_rise, vs_fall;
   logic        unused_edges;

   assign unused_edges = de_rise ^ hs_fall ^ vs_fall;

   scv_sync_edge u_de_edge (
      .clk   (clk),
      .rst   (rst),
      .ce_i  (vid.ce),
      .d_i   (vid.de),
      .rise_o(de_rise),
      .fall_o(de_fall)
   );

   scv_sync_edge u_hs_edge (
      .clk   (clk),
      .rst   (rst),
      .ce_i  (vid.ce),
      .d_i   (vid.hs),
      .rise_o(hs_rise),
      .fall_o(hs_fall)
   );

   scv_sync_edge u_vs_edge (
      .clk   (clk),
      .rst   (rst),
      .ce_i  (vid.ce),
      .d_i   (vid.vs),
      .rise_o(vs_rise),
      .fall_o(vs_fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         x_q       <= '0;
         y_q       <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         width_o   <= '0;
         height_o  <= '0;
         hlines_o  <= '0;
         err_o     <= '0;
         vid.fb_a  <= '0;
         vid.fb_d  <= '0;
         vid.fb_we <= 1'b0;
      end else begin
         vid.fb_we <= 1'b0;
         case (state_q)
            StIdle, StDone: begin
               if (arm_i) begin
                  state_q  <= StWaitVs;
                  busy_o   <= 1'b1;
                  done_o   <= 1'b0;
                  width_o  <= '0;
                  height_o <= '0;
                  hlines_o <= '0;
                  err_o    <= '0;
                  x_q      <= '0;
                  y_q      <= '0;
               end
            end
            StWaitVs: begin
               if (vs_rise) state_q <= StWaitVsLow;
            end
            StWaitVsLow: begin
               if (vid.ce && !vid.vs) state_q <= StCapture;
            end
            StCapture: begin
               // A pixel coinciding with the closing VS edge belongs to no frame.
               if (vid.ce && vid.de && !vs_rise) begin
                  if (x_q >= XMax) err_o[ErrXOvfIdx] <= 1'b1;
                  if (y_q >= YMax) err_o[ErrYOvfIdx] <= 1'b1;
                  if (x_q < XMax && y_q < YMax) begin
                     vid.fb_a  <= {y_q[YW-1:0], x_q[XW-1:0]};
                     vid.fb_d  <= vid.rgb;
                     vid.fb_we <= 1'b1;
                  end
                  if (x_q < XMax) x_q <= x_q + 1'b1;
               end
               if (de_fall) begin
                  if (y_q == '0) begin
                     width_o <= x_q;
                  end else if (x_q != width_o) begin
                     err_o[ErrWidthIdx] <= 1'b1;
                  end
                  x_q <= '0;
                  if (y_q < YMax) begin
                     y_q      <= y_q + 1'b1;
                     height_o <= y_q + 1'b1;
                  end
               end
               if (hs_rise && hlines_o != HlMax) hlines_o <= hlines_o + 1'b1;
               if (vs_rise) begin
                  state_q <= StDone;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/scv_video_capture.md
Name: scv_video_capture

Overview:
Pixel-stream sink for the epochtv1 video output. It takes the DE/HS/VS/RGB stream, which is qualified by the pixel clock-enable, and captures exactly one frame into an external framebuffer RAM through a write port addressed as {y,x}. It also reports the measured active geometry and any stream errors. It is used in simulation and on-target for frame grabs and render regression checks.

Parameters:
XW, 8, x address width; maximum active pixels per line is 2**XW
YW, 8, y address width; maximum active lines per frame is 2**YW

Ports:
CLK  in  1  system clock (2x 14.318181 MHz)
RES  in  1  synchronous active-high reset
CE  in  1  pixel clock-enable; all stream inputs are sampled only when CE=1
DE  in  1  active-video enable
HS  in  1  horizontal sync, active-high
VS  in  1  vertical sync, active-high
RGB  in  24  pixel colour {R,G,B}
ARM  in  1  one-cycle pulse that requests capture of the next full frame
BUSY  out  1  armed or capturing
DONE  out  1  held high once a frame is complete, until the next ARM or RES
FB_A  out  XW+YW  framebuffer address {y,x}
FB_D  out  24  framebuffer write data
FB_WE  out  1  framebuffer write strobe, one CLK cycle wide
WIDTH  out  XW+1  active pixel count of the first captured line
HEIGHT  out  YW+1  count of active lines captured
HLINES  out  10  count of HS rising edges during capture (total lines)
ERR  out  3  sticky flags: [0] line width mismatch, [1] x overflow, [2] y overflow

Behaviour:
- Clock and reset: one clock, CLK. RES is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, DE/HS/VS history registers 0.
- Edge detection: the previous DE/HS/VS values are registered only on CE cycles. A rising or falling edge exists only on a CE cycle, comparing the current sample with the previous one.
- States: IDLE, WAIT_VS, WAIT_VS_LOW, CAPTURE, DONE.
  - IDLE/DONE, ARM=1: go to WAIT_VS. Clear WIDTH, HEIGHT, HLINES, ERR, x, y. Clear DONE.
  - WAIT_VS, VS rising edge: go to WAIT_VS_LOW.
  - WAIT_VS_LOW, VS sampled 0 on a CE cycle: go to CAPTURE.
  - CAPTURE, VS rising edge: go to DONE. HEIGHT holds the final y count.
  - ARM while in WAIT_VS, WAIT_VS_LOW or CAPTURE is ignored.
- BUSY = 1 in WAIT_VS, WAIT_VS_LOW and CAPTURE. DONE = 1 in the DONE state.
- Pixel write, CAPTURE, CE=1, DE=1:
  - If x < 2**XW: on the next CLK edge FB_A={y,x}, FB_D=RGB, FB_WE=1, for exactly 1 cycle. Latency from the sampling edge is 1 CLK.
  - If y >= 2**YW, the write is suppressed and ERR[2] is set.
  - If x >= 2**XW, the write is suppressed and ERR[1] is set.
  - x increments and saturates at 2**XW.
- End of line, CAPTURE, DE falling edge:
  - If y==0, WIDTH<=x. Otherwise, if x != WIDTH, ERR[0] is set.
  - Then x<=0. y increments and saturates at 2**YW. HEIGHT<=y+1, saturating.
- HS rising edge in CAPTURE: HLINES increments and saturates at 1023.
- Simultaneous events:
  - A VS rising edge on the same CE as a DE falling edge: the line end is processed first, then the state moves to DONE.
  - DE=1 on the VS rising CE: that pixel is not written.
- FB_WE is 0 in every state other than CAPTURE.
- FB_A and FB_D hold their last values when FB_WE=0.
- RES mid-capture returns everything to reset values immediately. Any framebuffer contents already written are undefined to the consumer.
- When CE=0, no state change occurs except ARM handling.

Decomposition:
- Package scv_video_pkg:
  - capture state enum (IDLE, WAIT_VS, WAIT_VS_LOW, CAPTURE, DONE)
  - ERR bit index constants
  - rgb_t typedef, 24-bit {r,g,b} bytes
- One sub-module, scv_sync_edge: CE-qualified registered edge detector for a single signal, with rise and fall outputs. It is instantiated three times, for DE, HS and VS.

Test Plan:
- Synthetic frame:
  - Stimulus: 4 lines x 6 pixels, RGB = {8'(y),8'(x),8'h5A}, CE every 7th CLK, ARM before VS.
  - Required: 24 FB_WE pulses, each 1 cycle wide. FB_A={y,x}. WIDTH=6, HEIGHT=4, ERR=0, DONE=1, BUSY=0.
- Mid-frame arm:
  - Stimulus: ARM during line 2 of an active frame.
  - Required: no writes until after the next VS falls. The following frame is captured fully starting at y=0.
- Width mismatch:
  - Stimulus: line 0 has 6 pixels, line 1 has 5.
  - Required: WIDTH=6, ERR[0]=1. Capture continues and HEIGHT counts all lines.
- Overflow:
  - Stimulus: XW=3 with 10-pixel lines.
  - Required: 8 writes per line at x=0..7, ERR[1]=1, WIDTH=8 (saturated).
- Reset and re-arm:
  - Stimulus: RES asserted for 1 cycle mid-line during CAPTURE.
  - Required: the next CLK shows all outputs 0 and state IDLE. A re-ARM then captures a clean frame with ERR=0.
- Epochtv1 integration:
  - Stimulus: drive from dut DE/HS/VS/RGB with the VRAM image loaded.
  - Required: WIDTH and HEIGHT match the render.hex line length and line count. HLINES equals the epochtv1 total line count.
